sync_fifo_reader: RTL and testbench



---
 rtl/sync_fifo_reader_pkg.sv | 20 ++
 rtl/sync_fifo_reader_if.sv | 28 ++
 rtl/sync_fifo_reader_stream_out_buffer.sv | 54 +++++
 rtl/sync_fifo_reader.sv | 54 +++++
 tb/tb_sync_fifo_reader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_reader_pkg.sv
// Constants shared by sync_fifo and its reader so that the flag thresholds
// and buffer sizing cannot drift apart between the two blocks.
package sync_fifo_reader_pkg;

  localparam int c_ALMOST_EMPTY_THRESHOLD = 1;
  localparam int c_BUFFER_DEPTH           = 2;
  localparam int c_FLAG_LATENCY           = 1;

  typedef enum logic [1:0] {
    BUF_HOLD   = 2'b00,
    BUF_SHIFT  = 2'b01,
    BUF_APPEND = 2'b10,
    BUF_SWAP   = 2'b11
  } buf_op_t;

  function automatic buf_op_t buf_op(input logic capture, input logic pop);
    return buf_op_t'({capture, pop});
  endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO-side and stream-side signals of the reader, named from the reader's
// point of view; master is the reader, slave is the FIFO plus consumer.
interface sync_fifo_reader_if
  import sync_fifo_reader_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8
);

  logic                                   i_FIFO_EMPTY;
  logic                                   i_FIFO_ALMOST_EMPTY;
  logic [p_DATA_WIDTH-1:0]                i_FIFO_DATA;
  logic                                   o_FIFO_READ_REQUEST;
  logic                                   o_VALID;
  logic [p_DATA_WIDTH-1:0]                o_DATA;
  logic                                   i_READY;
  logic [$clog2(c_BUFFER_DEPTH+1)-1:0]    o_COUNT;

  modport master (
    input  i_FIFO_EMPTY, i_FIFO_ALMOST_EMPTY, i_FIFO_DATA, i_READY,
    output o_FIFO_READ_REQUEST, o_VALID, o_DATA, o_COUNT
  );

  modport slave (
    output i_FIFO_EMPTY, i_FIFO_ALMOST_EMPTY, i_FIFO_DATA, i_READY,
    input  o_FIFO_READ_REQUEST, o_VALID, o_DATA, o_COUNT
  );

endinterface

// File: rtl/sync_fifo_reader_stream_out_buffer.sv
// Two-entry ordered output buffer: head is presented downstream, tail holds
// the next word. Capture and pop may happen in the same edge.
module stream_out_buffer
  import sync_fifo_reader_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET_N,
  input  logic                    i_CAPTURE,
  input  logic                    i_POP,
  input  logic [p_DATA_WIDTH-1:0] i_DATA,
  output logic [1:0]              o_COUNT,
  output logic [p_DATA_WIDTH-1:0] o_HEAD
);

  logic [p_DATA_WIDTH-1:0] r_head;
  logic [p_DATA_WIDTH-1:0] r_tail;
  logic [1:0]              r_count;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (buf_op(i_CAPTURE, i_POP))
        BUF_APPEND: begin
          if (r_count == 2'd0) r_head <= i_DATA;
          else                 r_tail <= i_DATA;
          r_count <= r_count + 2'd1;
        end
        BUF_SHIFT: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // occupancy unchanged; the new word lands behind whatever survives the pop
        BUF_SWAP: begin
          if (r_count == 2'd1) begin
            r_head <= i_DATA;
          end else begin
            r_head <= r_tail;
            r_tail <= i_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_COUNT = r_count;
  assign o_HEAD  = r_head;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for sync_fifo: issues reads from the stale flags,
// tracks the one outstanding read, and streams words out via valid/ready.
module sync_fifo_reader
  import sync_fifo_reader_pkg::*;
#(
  parameter int p_DATA_WIDTH        = 8,
  parameter int p_ALMOST_EMPTY_FLAG = 1
) (
  input  logic              i_CLK,
  input  logic              i_RESET_N,
  input  logic              i_ENABLE,
  sync_fifo_reader_if.master bus
);

  // An unsupported threshold would make the level decode unsafe, so reads stay off.
  localparam logic c_THRESHOLD_OK = (p_ALMOST_EMPTY_FLAG == c_ALMOST_EMPTY_THRESHOLD);

  logic [c_FLAG_LATENCY-1:0] r_inflight;
  logic [1:0]                w_count;
  logic                      w_pop;
  logic [2:0]                w_committed;
  logic                      w_read;

  assign w_pop       = bus.o_VALID & bus.i_READY;
  assign w_committed = {1'b0, w_count} + {2'b00, r_inflight[0]} - {2'b00, w_pop};

  // At level 1 the flags cannot yet see a read issued last cycle.
  assign w_read = i_RESET_N & c_THRESHOLD_OK & i_ENABLE
                & ~bus.i_FIFO_EMPTY
                & (~bus.i_FIFO_ALMOST_EMPTY | ~r_inflight[0])
                & (w_committed < 3'(c_BUFFER_DEPTH));

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) r_inflight <= '0;
    else            r_inflight <= w_read;
  end

  stream_out_buffer #(
    .p_DATA_WIDTH (p_DATA_WIDTH)
  ) u_stream_out_buffer (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .i_CAPTURE (r_inflight[0]),
    .i_POP     (w_pop),
    .i_DATA    (bus.i_FIFO_DATA),
    .o_COUNT   (w_count),
    .o_HEAD    (bus.o_DATA)
  );

  assign bus.o_FIFO_READ_REQUEST = w_read;
  assign bus.o_COUNT             = w_count;
  assign bus.o_VALID             = (w_count != 2'd0);

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed plus random stimulus for sync_fifo_reader against a queue model
// of the FIFO contents and the expected output stream.
module tb_sync_fifo_reader;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;

  sync_fifo_reader_if #(.p_DATA_WIDTH(8)) bus();

  sync_fifo_reader #(
    .p_DATA_WIDTH        (8),
    .p_ALMOST_EMPTY_FLAG (1)
  ) dut (
    .i_CLK     (clk),
    .i_RESET_N (rst_n),
    .i_ENABLE  (enable),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         mdl_cnt;
  logic       mdl_inflight;
  int         n_req;
  logic       last_req, last_valid;
  logic [7:0] last_data;
  logic [1:0] last_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic settle_flags();
    bus.i_FIFO_EMPTY        = (fifo_q.size() == 0);
    bus.i_FIFO_ALMOST_EMPTY = (fifo_q.size() <= 1);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic pop;
    int   sz;
    #1;
    last_req   = bus.o_FIFO_READ_REQUEST;
    last_valid = bus.o_VALID;
    last_data  = bus.o_DATA;
    last_count = bus.o_COUNT;
    chk("count", 32'(last_count), 32'(mdl_cnt));
    chk("valid", 32'(last_valid), 32'(mdl_cnt != 0));
    if (last_valid) begin
      chk("stream_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("data_order", 32'(last_data), 32'(exp_q[0]));
    end
    if (last_req) begin
      chk("read_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      n_req++;
    end
    pop = last_valid & bus.i_READY;
    @(posedge clk);
    #1;
    sz = fifo_q.size();
    bus.i_FIFO_EMPTY        = (sz == 0);
    bus.i_FIFO_ALMOST_EMPTY = (sz <= 1);
    if (last_req && sz > 0) bus.i_FIFO_DATA = fifo_q.pop_front();
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    mdl_cnt      = mdl_cnt + int'(mdl_inflight) - int'(pop);
    mdl_inflight = last_req;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    repeat (2) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_FIFO_EMPTY        = 1'b0;
    bus.i_FIFO_ALMOST_EMPTY = 1'b0;
    bus.i_FIFO_DATA         = 8'h00;
    bus.i_READY             = 1'b1;
    enable                  = 1'b1;
    mdl_cnt                 = 0;
    mdl_inflight            = 1'b0;
    n_req                   = 0;

    // reset state with every other read condition true
    #2;
    chk("rst_valid", 32'(bus.o_VALID), 32'd0);
    chk("rst_count", 32'(bus.o_COUNT), 32'd0);
    chk("rst_data",  32'(bus.o_DATA),  32'd0);
    chk("rst_req",   32'(bus.o_FIFO_READ_REQUEST), 32'd0);
    settle_flags();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // three preloaded words streamed back to back
    n_req = 0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    settle_flags();
    cycle(); chk("t1_req_c0",   32'(last_req),   32'd1);
    cycle(); chk("t1_valid_c1", 32'(last_valid), 32'd0);
    cycle(); chk("t1_valid_c2", 32'(last_valid), 32'd1);
             chk("t1_data_c2",  32'(last_data),  32'hA1);
    cycle(); chk("t1_data_c3",  32'(last_data),  32'hA2);
    cycle(); chk("t1_data_c4",  32'(last_data),  32'hA3);
    repeat (3) cycle();
    chk("t1_reads", 32'(n_req), 32'd3);
    chk("t1_done",  32'(exp_q.size()), 32'd0);

    // single word: read suppressed next cycle despite stale flags
    n_req = 0;
    push(8'h5C);
    settle_flags();
    cycle(); chk("t2_req_c0",  32'(last_req),  32'd1);
    cycle(); chk("t2_req_c1",  32'(last_req),  32'd0);
    cycle(); chk("t2_data",    32'(last_data), 32'h5C);
    repeat (3) cycle();
    chk("t2_reads",      32'(n_req), 32'd1);
    chk("t2_emit_once",  32'(last_valid), 32'd0);

    // backpressure
    n_req = 0;
    bus.i_READY = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    settle_flags();
    repeat (5) cycle();
    chk("t3_count_full", 32'(last_count), 32'd2);
    chk("t3_req_low",    32'(last_req),   32'd0);
    chk("t3_fifo_left",  32'(fifo_q.size()), 32'd1);
    bus.i_READY = 1'b1;
    drain(20);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_reads",   32'(n_req), 32'd3);

    // enable dropped right after a request
    n_req = 0;
    push(8'h11); push(8'h22);
    settle_flags();
    cycle(); chk("t4_req", 32'(last_req), 32'd1);
    enable = 1'b0;
    cycle(); chk("t4_req_disabled", 32'(last_req), 32'd0);
    repeat (4) cycle();
    chk("t4_reads",     32'(n_req), 32'd1);
    chk("t4_fifo_left", 32'(fifo_q.size()), 32'd1);
    chk("t4_emitted",   32'(exp_q.size()), 32'd1);
    enable = 1'b1;
    drain(20);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // capture and pop together at occupancy 1
    push(8'h31); push(8'h32);
    settle_flags();
    cycle(); cycle();
    cycle(); chk("t5_count_c2", 32'(last_count), 32'd1);
             chk("t5_data_c2",  32'(last_data),  32'h31);
    cycle(); chk("t5_count_c3", 32'(last_count), 32'd1);
             chk("t5_data_c3",  32'(last_data),  32'h32);
    drain(20);

    // random traffic
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        push(8'($urandom));
        if ($urandom_range(0, 1) == 0) push(8'($urandom));
      end
      bus.i_READY = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      cycle();
    end
    enable = 1'b1;
    bus.i_READY = 1'b1;
    drain(80);
    chk("rand_drained",    32'(exp_q.size()),  32'd0);
    chk("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // asynchronous reset mid-stream with a read outstanding
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    settle_flags();
    cycle(); cycle();
    #2;
    chk("t6_pre_count", 32'(bus.o_COUNT), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.o_VALID), 32'd0);
    chk("t6_count", 32'(bus.o_COUNT), 32'd0);
    chk("t6_req",   32'(bus.o_FIFO_READ_REQUEST), 32'd0);
    chk("t6_data",  32'(bus.o_DATA),  32'd0);
    fifo_q.delete();
    exp_q.delete();
    settle_flags();
    bus.i_FIFO_DATA = 8'hEE;
    mdl_cnt      = 0;
    mdl_inflight = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("t6_no_capture", 32'(last_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
